// File: rtl/event_read_sequencer.sv
// Event readout sequencer: drains EVENT_WORDS words from each unmasked channel FIFO,
// in ascending channel order, into the output FIFO between a header and a trailer word.
module event_read_sequencer #(
    parameter int EVENT_WORDS = 16,
    parameter int WAIT_LIMIT  = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          read_submit,
    input  logic          live_rising,
    input  logic [15:0]   input_mask,
    input  logic [15:0]   ch_empty,
    input  logic [255:0]  ch_data,
    output logic [15:0]   ch_rd_en,
    input  logic          out_afull,
    output logic          out_wr,
    output logic [15:0]   out_data,
    output logic          busy,
    output logic [15:0]   timeout_mask,
    output logic          submit_overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_SELECT  = 3'd2,
        S_READ    = 3'd3,
        S_DRAIN   = 3'd4,
        S_TRAILER = 3'd5
    } state_t;

    state_t       state_q;
    logic [15:0]  pend_q;
    logic [15:0]  tmo_acc_q;
    logic [4:0]   nch_q;
    logic [3:0]   ch_q;
    logic [7:0]   words_left_q;
    logic [15:0]  wait_cnt_q;
    logic [11:0]  evt_cnt_q;
    logic         rd_q;
    logic         out_wr_q;
    logic [15:0]  out_data_q;
    logic         busy_q;
    logic [15:0]  timeout_mask_q;
    logic         submit_overrun_q;

    logic         rd_go_s;
    logic [7:0]   words_left_d;
    logic [15:0]  wait_cnt_d;
    logic [3:0]   sel_ch_d;
    logic [15:0]  chan_word_s;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    assign words_left_d = words_left_q - 8'd1;
    assign wait_cnt_d   = wait_cnt_q + 16'd1;
    assign sel_ch_d     = lowest_set(pend_q);
    assign chan_word_s  = ch_data[{ch_q, 4'b0000} +: 16];
    assign rd_go_s      = (state_q == S_READ) && !ch_empty[ch_q] && !out_afull &&
                          (words_left_q != 8'd0);

    // Read strobe for the active channel only; never more than one bit
    always_comb begin
        ch_rd_en = 16'd0;
        if (rd_go_s) ch_rd_en[ch_q] = 1'b1;
        else         ch_rd_en = 16'd0;
    end

    // Sequencer FSM, read pipeline and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            pend_q           <= 16'd0;
            tmo_acc_q        <= 16'd0;
            nch_q            <= 5'd0;
            ch_q             <= 4'd0;
            words_left_q     <= 8'd0;
            wait_cnt_q       <= 16'd0;
            evt_cnt_q        <= 12'd0;
            rd_q             <= 1'b0;
            out_wr_q         <= 1'b0;
            out_data_q       <= 16'd0;
            busy_q           <= 1'b0;
            timeout_mask_q   <= 16'd0;
            submit_overrun_q <= 1'b0;
        end else begin
            // A word read last cycle is valid now and goes straight to the output
            rd_q     <= rd_go_s;
            out_wr_q <= rd_q;
            if (rd_q) out_data_q <= chan_word_s;

            if (live_rising) begin
                submit_overrun_q <= 1'b0;
                timeout_mask_q   <= 16'd0;
            end
            if (read_submit && (state_q != S_IDLE)) submit_overrun_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (read_submit) begin
                        pend_q    <= ~input_mask;
                        tmo_acc_q <= 16'd0;
                        nch_q     <= 5'd0;
                        busy_q    <= 1'b1;
                        state_q   <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (!out_afull) begin
                        out_wr_q   <= 1'b1;
                        out_data_q <= {4'hA, evt_cnt_q};
                        state_q    <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (pend_q == 16'd0) begin
                        state_q <= S_TRAILER;
                    end else begin
                        ch_q         <= sel_ch_d;
                        pend_q       <= pend_q & ~(16'd1 << sel_ch_d);
                        words_left_q <= 8'(EVENT_WORDS);
                        wait_cnt_q   <= 16'd0;
                        nch_q        <= nch_q + 5'd1;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    // Only an empty channel advances the stall counter, never backpressure
                    if (rd_go_s) begin
                        words_left_q <= words_left_d;
                        wait_cnt_q   <= 16'd0;
                        if (words_left_d == 8'd0) state_q <= S_DRAIN;
                    end else if (ch_empty[ch_q]) begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_d == 16'(WAIT_LIMIT)) begin
                            tmo_acc_q[ch_q] <= 1'b1;
                            state_q         <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    state_q <= S_SELECT;
                end
                S_TRAILER: begin
                    if (!out_afull) begin
                        out_wr_q       <= 1'b1;
                        out_data_q     <= {4'hE, 6'b000000, |tmo_acc_q, nch_q};
                        timeout_mask_q <= tmo_acc_q;
                        evt_cnt_q      <= evt_cnt_q + 12'd1;
                        busy_q         <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_wr         = out_wr_q;
    assign out_data       = out_data_q;
    assign busy           = busy_q;
    assign timeout_mask   = timeout_mask_q;
    assign submit_overrun = submit_overrun_q;

endmodule
